int_controller: RTL and testbench



---
 rtl/int_controller.sv | 167 ++++++++++++++++
 tb/tb_int_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// rtl/int_controller.sv - parametrised edge/level interrupt controller with fixed-priority request/ack handshake
//
// Ports:
//   clk, nreset          clock, synchronous active-low reset
//   irq_in               raw asynchronous interrupt sources, active-high
//   cfg_we, cfg_addr     register write strobe and register select
//   cfg_d, cfg_q         register write data, registered read data
//   int_req, int_id      request to the CPU and the channel being requested
//   int_ack              one-cycle CPU acknowledge of the current request
// Registers: 0 MASK, 1 MODE (1 = edge), 2 PENDING (W1C), 3 STATUS {int_id, int_req}

module int_controller #(
    parameter int N_CHANNELS  = 8,
    parameter int ID_WIDTH    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [N_CHANNELS-1:0] irq_in,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_d,
    output logic [31:0]           cfg_q,
    output logic                  int_req,
    output logic [ID_WIDTH-1:0]   int_id,
    input  logic                  int_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_t;

    state_t state, state_next;

    logic [N_CHANNELS-1:0] sync_ff [SYNC_STAGES];
    logic [N_CHANNELS-1:0] sync, prev, rise;
    logic [N_CHANNELS-1:0] pending, pend_next, clr, eligible;
    logic [N_CHANNELS-1:0] mask, mode;
    logic [N_CHANNELS-1:0] wr_data;
    logic [ID_WIDTH-1:0]   id_r, arb_id;
    logic                  arb_hit;
    logic [31:0]           rd_data;
    logic                  unused_cfg_d;

    assign wr_data      = cfg_d[N_CHANNELS-1:0];
    assign unused_cfg_d = ^cfg_d;

    // Input synchroniser plus one extra flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= '0;
            end
            prev <= '0;
        end else begin
            sync_ff[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
            prev <= sync;
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];
    assign rise = sync & ~prev;

    // Clear sources for edge channels: W1C write and acknowledge of the
    // channel currently being requested.
    always_comb begin
        clr = '0;
        if (cfg_we && cfg_addr == 2'd2) begin
            clr = wr_data;
        end
        if (state == ST_REQ && int_ack) begin
            clr[id_r] = 1'b1;
        end
    end

    // Edge channels: a new edge beats a simultaneous clear. Level channels
    // follow the synchronised input through the same register so both modes
    // see the same latency.
    assign pend_next = (mode & (rise | (pending & ~clr))) | (~mode & sync);
    assign eligible  = pending & mask;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pending <= '0;
        end else begin
            pending <= pend_next;
        end
    end

    // Fixed priority: lowest index wins, so scan downwards and let the last hit stand.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        for (int k = N_CHANNELS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                arb_hit = 1'b1;
                arb_id  = ID_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_IDLE;
            id_r  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && arb_hit) begin
                id_r <= arb_id;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (arb_hit) state_next = ST_REQ;
            ST_REQ:  if (int_ack) state_next = ST_GAP;
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign int_req = (state == ST_REQ);
    assign int_id  = int_req ? id_r : '0;

    // Configuration registers; writes land at the strobe edge, so an
    // arbitration in the same cycle still sees the old MASK.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            mask <= '0;
            mode <= '1;
        end else if (cfg_we) begin
            if (cfg_addr == 2'd0) mask <= wr_data;
            if (cfg_addr == 2'd1) mode <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        case (cfg_addr)
            2'd0: rd_data[N_CHANNELS-1:0] = mask;
            2'd1: rd_data[N_CHANNELS-1:0] = mode;
            2'd2: rd_data[N_CHANNELS-1:0] = pending;
            default: begin
                rd_data[0] = int_req;
                for (int b = 0; b < ID_WIDTH && b < 8; b++) begin
                    rd_data[b+1] = int_id[b];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= rd_data;
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - scoreboard bench for int_controller with random and scenario stimulus

module tb_int_controller;

    localparam int N = 8;
    localparam int S = 2;
    localparam int IW = 3;
    localparam int HMAX = 8192;

    logic          clk = 1'b0;
    logic          nreset;
    logic [N-1:0]  irq_in;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_d;
    logic [31:0]   cfg_q;
    logic          int_req;
    logic [IW-1:0] int_id;
    logic          int_ack;

    int_controller #(.N_CHANNELS(N), .ID_WIDTH(IW), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .irq_in   (irq_in),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_d    (cfg_d),
        .cfg_q    (cfg_q),
        .int_req  (int_req),
        .int_id   (int_id),
        .int_ack  (int_ack)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct { int e; logic [31:0] v; } rd_t;
    typedef struct { int e; logic lvl; int id; } ev_t;
    rd_t rdq[$];
    ev_t evq[$];

    int errors = 0;
    int checks = 0;

    // Reference model: input history indexed by clock edge, plus the
    // architectural state the CPU can observe.
    logic [N-1:0] hist [HMAX];
    int           r_edge = 0;
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] m_mode = '1;
    logic [N-1:0] m_pend = '0;
    int           m_req  = -1;
    bit           m_gap  = 0;
    logic [N-1:0] irq_v  = '0;

    // Value the source had just before edge i, as seen after the most recent reset.
    function automatic logic [N-1:0] h(input int i);
        if (i <= r_edge || i < 0) return '0;
        return hist[i];
    endfunction

    task automatic model_edge(input int e);
        logic [N-1:0] sy, pv, rise, clr, elig;
        logic [31:0]  rd;
        ev_t          ev;
        hist[e] = irq_in;
        case (cfg_addr)
            2'd0: rd = {24'b0, m_mask};
            2'd1: rd = {24'b0, m_mode};
            2'd2: rd = {24'b0, m_pend};
            default: rd = (m_req >= 0) ? ((32'(m_req) << 1) | 32'd1) : 32'd0;
        endcase
        if (!nreset) begin
            rdq.push_back('{e, 32'd0});
            if (m_req >= 0) begin
                ev = '{e, 1'b0, 0};
                evq.push_back(ev);
            end
            m_req = -1; m_gap = 0; m_mask = '0; m_mode = '1; m_pend = '0;
            r_edge = e;
            return;
        end
        rdq.push_back('{e, rd});
        // sync before edge e was sampled S-1 edges earlier; prev one edge before that.
        sy   = h(e - S);
        pv   = h(e - S - 1);
        rise = sy & ~pv;
        clr  = '0;
        if (cfg_we && cfg_addr == 2'd2) clr = cfg_d[N-1:0];
        elig = m_pend & m_mask;
        if (m_req >= 0) begin
            if (int_ack) begin
                clr[m_req] = 1'b1;
                evq.push_back('{e, 1'b0, 0});
                m_req = -1;
                m_gap = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (elig != 0) begin
            for (int k = 0; k < N; k++) begin
                if (elig[k]) begin
                    m_req = k;
                    break;
                end
            end
            evq.push_back('{e, 1'b1, m_req});
        end
        for (int k = 0; k < N; k++) begin
            m_pend[k] = m_mode[k] ? (rise[k] | (m_pend[k] & ~clr[k])) : sy[k];
        end
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_d[N-1:0];
        if (cfg_we && cfg_addr == 2'd1) m_mode = cfg_d[N-1:0];
    endtask

    task automatic cyc(input logic we, input logic [1:0] addr, input logic [31:0] d,
                       input logic ack, input logic rstn);
        @(negedge clk);
        irq_in   = irq_v;
        cfg_we   = we;
        cfg_addr = addr;
        cfg_d    = d;
        int_ack  = ack;
        nreset   = rstn;
        model_edge(edge_n + 1);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'(i % 4), 32'd0, 1'b0, 1'b1);
    endtask

    // Monitor: compares every registered read and every int_req transition.
    logic last_req = 1'b0;
    always @(negedge clk) begin
        if (edge_n > 0) begin
            if (rdq.size() > 0 && rdq[0].e == edge_n) begin
                rd_t r;
                r = rdq.pop_front();
                checks++;
                if (cfg_q !== r.v) begin
                    errors++;
                    $display("FAIL cfg_q edge=%0d got=%h expected=%h", edge_n, cfg_q, r.v);
                end
            end
            if (evq.size() > 0 && evq[0].e == edge_n) begin
                ev_t ev;
                ev = evq.pop_front();
                checks++;
                if (int_req !== ev.lvl || (ev.lvl && int_id !== IW'(ev.id))) begin
                    errors++;
                    $display("FAIL int_req_event edge=%0d got req=%b id=%0d expected req=%b id=%0d",
                             edge_n, int_req, int_id, ev.lvl, ev.id);
                end
            end else if (int_req !== last_req) begin
                checks++;
                errors++;
                $display("FAIL unexpected_int_req edge=%0d got req=%b expected req=%b",
                         edge_n, int_req, last_req);
            end
            last_req = int_req;
        end
    end

    initial begin
        irq_in = '0; cfg_we = 0; cfg_addr = 0; cfg_d = 0; int_ack = 0; nreset = 0;
        for (int i = 0; i < HMAX; i++) hist[i] = '0;

        // Reset, then a single edge on channel 0.
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 32'h01, 1'b0, 1'b1);
        irq_v = 8'h01; nop(1); irq_v = 8'h00;
        nop(5);
        cyc(1'b0, 2'd2, 32'd0, 1'b1, 1'b1);
        nop(4);

        // Two simultaneous edges: channel 2 first, then 5.
        cyc(1'b1, 2'd0, 32'hFF, 1'b0, 1'b1);
        irq_v = 8'h24; nop(5);
        cyc(1'b0, 2'd3, 32'd0, 1'b1, 1'b1);
        nop(3);
        cyc(1'b0, 2'd3, 32'd0, 1'b1, 1'b1);
        irq_v = 8'h00; nop(4);

        // Level channel 3 held high and acknowledged continuously, then dropped.
        cyc(1'b1, 2'd1, 32'hF7, 1'b0, 1'b1);
        irq_v = 8'h08; nop(4);
        for (int i = 0; i < 9; i++) cyc(1'b0, 2'd3, 32'd0, 1'b1, 1'b1);
        irq_v = 8'h00;
        for (int i = 0; i < 6; i++) cyc(1'b0, 2'd2, 32'd0, 1'b1, 1'b1);
        cyc(1'b1, 2'd1, 32'hFF, 1'b0, 1'b1);
        nop(3);

        // Masked edge stays pending, unmask, W1C during REQ does not withdraw.
        cyc(1'b1, 2'd0, 32'h00, 1'b0, 1'b1);
        irq_v = 8'h02; nop(1); irq_v = 8'h00; nop(4);
        cyc(1'b0, 2'd2, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 32'h02, 1'b0, 1'b1);
        nop(2);
        cyc(1'b1, 2'd2, 32'h02, 1'b0, 1'b1);
        nop(3);
        cyc(1'b0, 2'd2, 32'd0, 1'b1, 1'b1);
        nop(4);

        // Channel 4: new edge coincides with its own acknowledge.
        cyc(1'b1, 2'd0, 32'h10, 1'b0, 1'b1);
        irq_v = 8'h10; nop(1); irq_v = 8'h00; nop(5);
        irq_v = 8'h10; nop(1); irq_v = 8'h00; nop(1);
        cyc(1'b0, 2'd2, 32'd0, 1'b1, 1'b1);
        nop(4);
        cyc(1'b0, 2'd2, 32'd0, 1'b1, 1'b1);
        nop(3);

        // Reset while requesting; no request afterwards without a new edge.
        irq_v = 8'h10; nop(1); irq_v = 8'h00; nop(5);
        cyc(1'b0, 2'd2, 32'd0, 1'b0, 1'b0);
        nop(8);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            irq_v = irq_v ^ (N'($urandom) & N'($urandom) & N'($urandom));
            cyc(($urandom % 6) == 0, 2'($urandom), $urandom, ($urandom % 3) == 0,
                ($urandom % 400) != 0);
        end
        nop(2);

        @(negedge clk);
        #1;
        checks++;
        if (evq.size() != 0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got events=%0d reads=%0d expected 0",
                     evq.size(), rdq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
